// File: rtl/nanorv32_rf_wb_sched_if.sv
// nanorv32_rf_wb_sched_if
// Writeback request bus between the execution units and the writeback scheduler.
//   req_valid [NUM_REQ]    : requester i has a write pending
//   req_rd    [5*NUM_REQ]  : destination register, requester i at [5i+4:5i]
//   req_data  [32*NUM_REQ] : write data, requester i at [32i+31:32i]
//   req_ready [NUM_REQ]    : request of requester i accepted this cycle
// master = requester side, slave = scheduler side.
interface nanorv32_rf_wb_sched_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [5*NUM_REQ-1:0]  req_rd;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;

  modport master (output req_valid, req_rd, req_data, input req_ready);
  modport slave  (input req_valid, req_rd, req_data, output req_ready);
endinterface

// File: rtl/nanorv32_rf_wb_sched.sv
// nanorv32_rf_wb_sched
// Writeback scheduler and scoreboard for the two-write-port register file.
// Round-robin arbitration of NUM_REQ requesters onto two registered write
// ports, with same-register conflict avoidance, plus a long-latency write
// scoreboard that stalls issue on RAW/WAW hazards.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   issue_valid/rd/long  : instruction being issued and its destination
//   issue_rs1/rs2        : sources of the instruction in issue
//   stall                : instruction in issue must not issue
//   req (slave)          : writeback request bus
//   sel_rd/rd/write_rd   : write port 1 select/data/enable (registered)
//   sel_rd2/rd2/write_rd2: write port 2 select/data/enable (registered)
//   busy                 : scoreboard, bit r = long write pending on xr
//   idle                 : no busy bits and no write enables
module nanorv32_rf_wb_sched #(
  parameter int                 NUM_REQ   = 3,
  parameter int                 NUM_REGS  = 32,
  parameter logic [NUM_REQ-1:0] LONG_MASK = 3'b110
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic [4:0]             issue_rd,
  input  logic                   issue_long,
  input  logic [4:0]             issue_rs1,
  input  logic [4:0]             issue_rs2,
  output logic                   stall,
  nanorv32_rf_wb_sched_if.slave  req,
  output logic [4:0]             sel_rd,
  output logic [31:0]            rd,
  output logic                   write_rd,
  output logic [4:0]             sel_rd2,
  output logic [31:0]            rd2,
  output logic                   write_rd2,
  output logic [NUM_REGS-1:0]    busy,
  output logic                   idle
);
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DATA_W = 32;

  logic [4:0]        rd_a   [NUM_REQ];
  logic [DATA_W-1:0] data_a [NUM_REQ];

  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  grant;
  logic                g1_vld, g2_vld;
  logic [PTR_W-1:0]    g1_idx, g2_idx;

  logic [NUM_REGS-1:0] busy_q, busy_d, busy_set, busy_clr;

  logic [4:0]        sel_rd_q,  sel_rd2_q;
  logic [DATA_W-1:0] rd_q,      rd2_q;
  logic              write_rd_q, write_rd2_q;
  logic [PTR_W-1:0]  src1_q,    src2_q;

  // Wraps a sum of two in-range indices back into 0..NUM_REQ-1.
  function automatic logic [PTR_W-1:0] wrap_idx(input int a);
    return (a >= NUM_REQ) ? PTR_W'(a - NUM_REQ) : PTR_W'(a);
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign rd_a[i]   = req.req_rd[5*i +: 5];
    assign data_a[i] = req.req_data[DATA_W*i +: DATA_W];
  end

  // Round-robin scan from ptr_q. A second requester that would write the
  // same non-zero register as port 1 is skipped so later ones can still win.
  always_comb begin
    grant  = '0;
    g1_vld = 1'b0;
    g2_vld = 1'b0;
    g1_idx = '0;
    g2_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [PTR_W-1:0] cand;
      cand = wrap_idx(int'(ptr_q) + k);
      if (req.req_valid[cand]) begin
        if (!g1_vld) begin
          g1_vld      = 1'b1;
          g1_idx      = cand;
          grant[cand] = 1'b1;
        end else if (!g2_vld && ((rd_a[cand] != rd_a[g1_idx]) ||
                                 (rd_a[cand] == '0) || (rd_a[g1_idx] == '0))) begin
          g2_vld      = 1'b1;
          g2_idx      = cand;
          grant[cand] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (g2_vld)      ptr_d = wrap_idx(int'(g2_idx) + 1);
    else if (g1_vld) ptr_d = wrap_idx(int'(g1_idx) + 1);
    else             ptr_d = ptr_q;
  end

  // Grants are discarded while reset is held.
  assign req.req_ready = grant & {NUM_REQ{rst_n}};

  assign stall = (busy_q[issue_rs1] && (issue_rs1 != '0)) ||
                 (busy_q[issue_rs2] && (issue_rs2 != '0)) ||
                 (issue_valid && busy_q[issue_rd] && (issue_rd != '0));

  // Clear comes from the registered writes, so the bit drops on the same
  // edge that updates the regfile; a new set on the same register wins.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (write_rd_q && LONG_MASK[src1_q])   busy_clr[sel_rd_q]  = 1'b1;
    if (write_rd2_q && LONG_MASK[src2_q])  busy_clr[sel_rd2_q] = 1'b1;
    if (issue_valid && issue_long && (issue_rd != '0) && !stall)
      busy_set[issue_rd] = 1'b1;
    busy_d    = (busy_q & ~busy_clr) | busy_set;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      busy_q      <= '0;
      sel_rd_q    <= '0;
      rd_q        <= '0;
      write_rd_q  <= 1'b0;
      src1_q      <= '0;
      sel_rd2_q   <= '0;
      rd2_q       <= '0;
      write_rd2_q <= 1'b0;
      src2_q      <= '0;
    end else begin
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      // A granted x0 write is consumed but never enabled.
      write_rd_q  <= g1_vld && (rd_a[g1_idx] != '0);
      write_rd2_q <= g2_vld && (rd_a[g2_idx] != '0);
      if (g1_vld) begin
        sel_rd_q <= rd_a[g1_idx];
        rd_q     <= data_a[g1_idx];
        src1_q   <= g1_idx;
      end
      if (g2_vld) begin
        sel_rd2_q <= rd_a[g2_idx];
        rd2_q     <= data_a[g2_idx];
        src2_q    <= g2_idx;
      end
    end
  end

  assign sel_rd    = sel_rd_q;
  assign rd        = rd_q;
  assign write_rd  = write_rd_q;
  assign sel_rd2   = sel_rd2_q;
  assign rd2       = rd2_q;
  assign write_rd2 = write_rd2_q;
  assign busy      = busy_q;
  assign idle      = (busy_q == '0) && !write_rd_q && !write_rd2_q;
endmodule

// File: doc/nanorv32_rf_wb_sched.md
Name: nanorv32_rf_wb_sched

Overview:
Writeback scheduler and scoreboard for the nanorv32 two-write-port register file. Arbitrates up to NUM_REQ writeback requesters (0 = ALU, 1 = LSU, 2 = MUL/DIV) onto the rd and rd2 write ports. Uses round-robin fairness and resolves same-register conflicts. Tracks registers with pending long-latency writes and raises a stall to the issue stage on RAW and WAW hazards.

Parameters:
NUM_REQ, 3, number of writeback requesters (verified at 3)
NUM_REGS, 32, architectural registers; x0 is never written or tracked
LONG_MASK, 3'b110, bit i set = requester i is long-latency and clears scoreboard entries

Ports:
clk  input  1  core clock
rst_n  input  1  reset, active-low, asynchronous assert
issue_valid  input  1  instruction issued this cycle
issue_rd  input  5  destination of issued instruction
issue_long  input  1  issued instruction writes back through a long requester
issue_rs1  input  5  source A of the instruction in issue (regfile sel_porta)
issue_rs2  input  5  source B of the instruction in issue (regfile sel_portb)
stall  output  1  hazard: the instruction in issue must not issue
req_valid  input  NUM_REQ  writeback request per requester
req_rd  input  5*NUM_REQ  destination register, packed, requester i at [5i+4:5i]
req_data  input  32*NUM_REQ  write data, packed
req_ready  output  NUM_REQ  request accepted this cycle
sel_rd  output  5  regfile write port 1 select
rd  output  32  regfile write port 1 data
write_rd  output  1  regfile write port 1 enable
sel_rd2  output  5  regfile write port 2 select
rd2  output  32  regfile write port 2 data
write_rd2  output  1  regfile write port 2 enable
busy  output  NUM_REGS  scoreboard, bit r = long write pending on xr
idle  output  1  no busy bits and no write enables asserted

Behaviour:
- Reset: all outputs are 0, except idle=1. The scoreboard is cleared and the round-robin pointer is 0.
- Arbitration (combinational, per cycle):
  - Scan requesters starting at pointer p, wrapping modulo NUM_REQ. The first valid requester gets port 1.
  - The next valid requester gets port 2 only if its rd differs from port 1's rd, or either rd is 0. Otherwise it is not granted and waits.
  - The scan continues past a rejected requester to a later valid requester with no conflict.
  - At most 2 grants per cycle. req_ready[i] = grant[i]; ready may depend on valid.
- Pointer update: if any grant occurs, p becomes (index of last granted + 1) mod NUM_REQ. Otherwise p is unchanged.
- Write outputs are registered:
  - A handshake in cycle N drives sel_rd, rd and write_rd (and the rd2 set) during cycle N+1. The regfile is updated at the end of N+1.
  - A granted rd=0 request is accepted with its write enable forced to 0. Its data is still registered.
  - With no grant on a port, that port's write enable is 0 and its select and data hold their previous values.
- Scoreboard:
  - Set: busy[issue_rd] is set when issue_valid && issue_long && issue_rd != 0 && !stall.
  - Clear: busy[r] is cleared at the end of cycle N+1 when a registered write from a LONG_MASK requester targets r. The source requester index is registered alongside the write outputs.
  - Consequence: stall releases in N+2, when the regfile read path already returns the new value.
  - If set and clear target the same r in the same cycle, set wins.
- stall (combinational) is asserted if any of these holds:
  - busy[issue_rs1] with issue_rs1 != 0;
  - busy[issue_rs2] with issue_rs2 != 0;
  - issue_valid && busy[issue_rd] with issue_rd != 0 (WAW).
  - stall is independent of req_* (no forwarding in this block).
- Protocol: a requester holds valid, rd and data stable until ready. A short requester whose rd is busy is not blocked by this block; the issue-side stall makes that impossible.
- idle = (busy == 0) && !write_rd && !write_rd2.
- Asynchronous reset mid-operation discards pending grants and scoreboard bits immediately. Write enables drop to 0 without waiting for a clock.

Test Plan:
- Reset, then a single ALU request (rd=5, data=32'hDEADBEEF): req_ready[0]=1 in cycle N; in N+1, write_rd=1, sel_rd=5, rd=DEADBEEF, write_rd2=0; p becomes 1.
- All three valid with rd=1/2/3, p=0: cycle 1 grants 0→port 1 and 1→port 2, p=2; cycle 2 grants 2→port 1 and 0 (still valid)→port 2; the fairness rotation is checked over 6 cycles.
- Requesters 1 and 2 both target rd=7, with 0 idle and p=1: only requester 1 is granted; requester 2 is granted the next cycle; never write_rd && write_rd2 with sel_rd == sel_rd2 != 0.
- Issue long to rd=10, then issue_rs1=10: stall=1 until the LSU writeback; handshake in N, write in N+1, stall=0 in N+2, busy[10]=0; idle returns to 1.
- rd=0 request from requester 2 with busy all 0: req_ready=1, write_rd=0 in N+1, busy unchanged; issue_valid with issue_rd=0 and issue_long=1 does not set busy[0].
- Same-cycle issue_long rd=12 and a completing long write to x12 (not stalled: busy[12] was clear via a prior race): busy[12]=1 afterwards. Assert rst_n low mid-traffic: write_rd, write_rd2 and busy go to 0 asynchronously.
